// File: rtl/parking_vagas_counter.sv
// parking_vagas_counter: free-space counter with synchronised, debounced entry/exit sensors and entry gate.
// Latency: sensor level change reaches count/flags/cancela DEBOUNCE_CYCLES+2 edges after first sampling edge.
// No backpressure: events are one-cycle pulses; rejected events (lot full/empty) leave the count untouched.
// Optional sticky error flag enabled by defining PARKING_ERRO_EN.

module parking_vagas_counter #(
  parameter int CAPACIDADE       = 9,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int GATE_OPEN_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_entrada,
  input  logic sensor_saida,
  input  logic limpar_erro,
  output logic b0,
  output logic b1,
  output logic b2,
  output logic b3,
  output logic lotado,
  output logic vazio,
  output logic cancela,
  output logic erro
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(GATE_OPEN_CYCLES + 1);

  localparam logic [3:0]    CAP        = 4'(CAPACIDADE);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(GATE_OPEN_CYCLES);

  typedef enum logic {FECHADA = 1'b0, ABERTA = 1'b1} gate_state_t;

  // Index 0 = entry loop, index 1 = exit loop.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_prev;
  logic [1:0]    armed;
  logic [DW-1:0] deb_cnt [2];

  logic ev_ent;
  logic ev_sai;

  logic [3:0] count;
  logic [3:0] count_next;
  logic       ent_ok;
  logic       rejeitado;

  gate_state_t   state_q;
  gate_state_t   state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          cancela_d;

  assign raw = {sensor_saida, sensor_entrada};

  // Two-flop synchroniser for the asynchronous loop sensors.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  // After reset a sensor is unarmed and must first be seen low for DEBOUNCE_CYCLES samples,
  // so a vehicle parked on the loop across reset does not produce a phantom event.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb   <= '0;
      armed <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!armed[i]) begin
          if (sync2[i]) begin
            deb_cnt[i] <= '0;
          end else if (deb_cnt[i] == DEB_LAST) begin
            armed[i]   <= 1'b1;
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_prev <= '0;
    end else begin
      deb_prev <= deb;
    end
  end

  assign ev_ent = deb[0] & ~deb_prev[0];
  assign ev_sai = deb[1] & ~deb_prev[1];

  // Event arbitration: saturating count, simultaneous entry+exit is a swap.
  always_comb begin
    count_next = count;
    ent_ok     = 1'b0;
    rejeitado  = 1'b0;
    case ({ev_ent, ev_sai})
      2'b11: begin
        ent_ok = 1'b1;
      end
      2'b10: begin
        if (count != 4'd0) begin
          count_next = count - 4'd1;
          ent_ok     = 1'b1;
        end else begin
          rejeitado = 1'b1;
        end
      end
      2'b01: begin
        if (count < CAP) begin
          count_next = count + 4'd1;
        end else begin
          rejeitado = 1'b1;
        end
      end
      default: begin
        count_next = count;
      end
    endcase
  end

  // Count register and flags, updated together so the decoder sees a coherent value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= CAP;
      lotado <= 1'b0;
      vazio  <= 1'b1;
    end else begin
      count  <= count_next;
      lotado <= (count_next == 4'd0);
      vazio  <= (count_next == CAP);
    end
  end

  assign b0 = count[3];
  assign b1 = count[2];
  assign b2 = count[1];
  assign b3 = count[0];

  // Gate FSM state and timer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FECHADA;
      timer_q <= '0;
      cancela <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cancela <= cancela_d;
    end
  end

  // Gate FSM next state: open on accepted entry, reload while open, close when timer hits 1.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      FECHADA: begin
        if (ent_ok) begin
          state_d = ABERTA;
          timer_d = TIMER_LOAD;
        end
      end
      ABERTA: begin
        if (ent_ok) begin
          timer_d = TIMER_LOAD;
        end else if (timer_q == TW'(1)) begin
          state_d = FECHADA;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = FECHADA;
        timer_d = '0;
      end
    endcase
  end

  // Gate FSM output: registered alongside the state so cancela is glitch-free.
  always_comb begin
    cancela_d = (state_d == ABERTA);
  end

`ifdef PARKING_ERRO_EN
  // Sticky error: a rejected event sets it, limpar_erro clears it, set wins on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      erro <= 1'b0;
    end else if (rejeitado) begin
      erro <= 1'b1;
    end else if (limpar_erro) begin
      erro <= 1'b0;
    end
  end
`else
  logic [1:0] unused_sigs;
  assign unused_sigs = {limpar_erro, rejeitado};
  assign erro        = 1'b0;
`endif

endmodule

// File: tb/tb_parking_vagas_counter.sv
// Directed self-checking bench for parking_vagas_counter (default parameters 9/4/8).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Error-flag expectations follow whether PARKING_ERRO_EN is defined for the build.

module tb_parking_vagas_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensor_entrada = 1'b0;
  logic sensor_saida = 1'b0;
  logic limpar_erro = 1'b0;
  logic b0, b1, b2, b3, lotado, vazio, cancela, erro;

  int n_checks = 0;
  int n_fail = 0;

`ifdef PARKING_ERRO_EN
  localparam logic ERR_ON_REJECT = 1'b1;
`else
  localparam logic ERR_ON_REJECT = 1'b0;
`endif

  parking_vagas_counter dut (
    .clk(clk),
    .reset(reset),
    .sensor_entrada(sensor_entrada),
    .sensor_saida(sensor_saida),
    .limpar_erro(limpar_erro),
    .b0(b0),
    .b1(b1),
    .b2(b2),
    .b3(b3),
    .lotado(lotado),
    .vazio(vazio),
    .cancela(cancela),
    .erro(erro)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] cnt();
    return {b0, b1, b2, b3};
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic ent, input logic sai, input int hi, input int lo);
    sensor_entrada = ent;
    sensor_saida   = sai;
    tick(hi);
    sensor_entrada = 1'b0;
    sensor_saida   = 1'b0;
    tick(lo);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (cnt() !== 4'b1001) begin n_fail++; $display("FAIL reset_count got %b want 1001", cnt()); end
    n_checks++; if (lotado !== 1'b0) begin n_fail++; $display("FAIL reset_lotado got %b want 0", lotado); end
    n_checks++; if (vazio !== 1'b1) begin n_fail++; $display("FAIL reset_vazio got %b want 1", vazio); end
    n_checks++; if (cancela !== 1'b0) begin n_fail++; $display("FAIL reset_cancela got %b want 0", cancela); end
    n_checks++; if (erro !== 1'b0) begin n_fail++; $display("FAIL reset_erro got %b want 0", erro); end
    tick(10);
  endtask

  task automatic test_exit_rejected();
    logic seen_open = 1'b0;
    sensor_saida = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (t == 10) sensor_saida = 1'b0;
      tick(1);
      if (cancela) seen_open = 1'b1;
    end
    n_checks++; if (cnt() !== 4'd9) begin n_fail++; $display("FAIL exit_full_count got %0d want 9", cnt()); end
    n_checks++; if (seen_open !== 1'b0) begin n_fail++; $display("FAIL exit_full_cancela got %b want 0", seen_open); end
    n_checks++; if (erro !== ERR_ON_REJECT) begin n_fail++; $display("FAIL exit_full_erro got %b want %b", erro, ERR_ON_REJECT); end
    limpar_erro = 1'b1;
    tick(1);
    limpar_erro = 1'b0;
    n_checks++; if (erro !== 1'b0) begin n_fail++; $display("FAIL exit_full_clear got %b want 0", erro); end
  endtask

  task automatic test_entry_latency();
    int open_cycles = 0;
    sensor_entrada = 1'b1;
    tick(6);
    n_checks++; if (cnt() !== 4'd9) begin n_fail++; $display("FAIL latency_early got %0d want 9", cnt()); end
    n_checks++; if (vazio !== 1'b1) begin n_fail++; $display("FAIL latency_vazio_early got %b want 1", vazio); end
    tick(1);
    n_checks++; if (cnt() !== 4'b1000) begin n_fail++; $display("FAIL latency_count got %b want 1000", cnt()); end
    n_checks++; if (vazio !== 1'b0) begin n_fail++; $display("FAIL latency_vazio got %b want 0", vazio); end
    if (cancela) open_cycles++;
    for (int t = 8; t <= 24; t++) begin
      if (t == 11) sensor_entrada = 1'b0;
      tick(1);
      if (cancela) open_cycles++;
      if (t == 14 && cancela !== 1'b1) begin n_fail++; $display("FAIL gate_last_open got %b want 1", cancela); end
      if (t == 14) n_checks++;
    end
    n_checks++; if (open_cycles !== 8) begin n_fail++; $display("FAIL gate_open_cycles got %0d want 8", open_cycles); end
    n_checks++; if (cnt() !== 4'd8) begin n_fail++; $display("FAIL latency_single got %0d want 8", cnt()); end
  endtask

  task automatic test_fill_and_reject();
    logic seen_open = 1'b0;
    for (int k = 0; k < 8; k++) pulse(1'b1, 1'b0, 8, 16);
    n_checks++; if (cnt() !== 4'd0) begin n_fail++; $display("FAIL fill_count got %0d want 0", cnt()); end
    n_checks++; if (lotado !== 1'b1) begin n_fail++; $display("FAIL fill_lotado got %b want 1", lotado); end
    n_checks++; if (cancela !== 1'b0) begin n_fail++; $display("FAIL fill_gate_closed got %b want 0", cancela); end
    sensor_entrada = 1'b1;
    for (int t = 0; t < 24; t++) begin
      if (t == 8) sensor_entrada = 1'b0;
      tick(1);
      if (cancela) seen_open = 1'b1;
    end
    n_checks++; if (cnt() !== 4'd0) begin n_fail++; $display("FAIL full_entry_count got %0d want 0", cnt()); end
    n_checks++; if (seen_open !== 1'b0) begin n_fail++; $display("FAIL full_entry_cancela got %b want 0", seen_open); end
    n_checks++; if (erro !== ERR_ON_REJECT) begin n_fail++; $display("FAIL full_entry_erro got %b want %b", erro, ERR_ON_REJECT); end
    limpar_erro = 1'b1;
    tick(1);
    limpar_erro = 1'b0;
    n_checks++; if (erro !== 1'b0) begin n_fail++; $display("FAIL full_entry_clear got %b want 0", erro); end
  endtask

  task automatic test_simultaneous_at_zero();
    sensor_entrada = 1'b1;
    sensor_saida   = 1'b1;
    tick(7);
    n_checks++; if (cnt() !== 4'd0) begin n_fail++; $display("FAIL swap_count got %0d want 0", cnt()); end
    n_checks++; if (cancela !== 1'b1) begin n_fail++; $display("FAIL swap_cancela got %b want 1", cancela); end
    n_checks++; if (erro !== 1'b0) begin n_fail++; $display("FAIL swap_erro got %b want 0", erro); end
    n_checks++; if (lotado !== 1'b1) begin n_fail++; $display("FAIL swap_lotado got %b want 1", lotado); end
    sensor_entrada = 1'b0;
    sensor_saida   = 1'b0;
    tick(16);
    n_checks++; if (cnt() !== 4'd0) begin n_fail++; $display("FAIL swap_after got %0d want 0", cnt()); end
  endtask

  task automatic test_glitch();
    do_reset();
    tick(10);
    pulse(1'b1, 1'b0, 3, 1);
    pulse(1'b1, 1'b0, 3, 12);
    n_checks++; if (cnt() !== 4'd9) begin n_fail++; $display("FAIL glitch_count got %0d want 9", cnt()); end
    n_checks++; if (cancela !== 1'b0) begin n_fail++; $display("FAIL glitch_cancela got %b want 0", cancela); end
    pulse(1'b1, 1'b0, 6, 12);
    n_checks++; if (cnt() !== 4'd8) begin n_fail++; $display("FAIL glitch_hold_count got %0d want 8", cnt()); end
  endtask

  task automatic test_reset_gate_open();
    pulse(1'b1, 1'b0, 8, 16);
    pulse(1'b1, 1'b0, 8, 16);
    sensor_entrada = 1'b1;
    tick(7);
    n_checks++; if (cnt() !== 4'd5) begin n_fail++; $display("FAIL pre_reset_count got %0d want 5", cnt()); end
    n_checks++; if (cancela !== 1'b1) begin n_fail++; $display("FAIL pre_reset_cancela got %b want 1", cancela); end
    reset = 1'b1;
    tick(1);
    n_checks++; if (cnt() !== 4'b1001) begin n_fail++; $display("FAIL midreset_count got %b want 1001", cnt()); end
    n_checks++; if (cancela !== 1'b0) begin n_fail++; $display("FAIL midreset_cancela got %b want 0", cancela); end
    n_checks++; if (vazio !== 1'b1) begin n_fail++; $display("FAIL midreset_vazio got %b want 1", vazio); end
    reset = 1'b0;
    tick(20);
    n_checks++; if (cnt() !== 4'd9) begin n_fail++; $display("FAIL held_sensor_count got %0d want 9", cnt()); end
    n_checks++; if (cancela !== 1'b0) begin n_fail++; $display("FAIL held_sensor_cancela got %b want 0", cancela); end
    sensor_entrada = 1'b0;
    tick(8);
    sensor_entrada = 1'b1;
    tick(7);
    n_checks++; if (cnt() !== 4'd8) begin n_fail++; $display("FAIL rearm_count got %0d want 8", cnt()); end
    n_checks++; if (cancela !== 1'b1) begin n_fail++; $display("FAIL rearm_cancela got %b want 1", cancela); end
    sensor_entrada = 1'b0;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_exit_rejected();
    test_entry_latency();
    test_fill_and_reject();
    test_simultaneous_at_zero();
    test_glitch();
    test_reset_gate_open();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
